// File: rtl/mmu_pkg.sv
// Shared types and helpers for the MMU job sequencer.
//   sched_state_e : sequencer FSM states
//   res_lat()     : cycles from an activation read strobe to its aligned result
//   lane_lo()     : low bit index of a lane inside a flat lane-packed bus
package mmu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_WT,
    COMPUTE,
    DRAIN,
    DONE
  } sched_state_e;

  // buffer read (1) + array pipeline + deskew/output register (SIZE)
  function automatic int res_lat(input int size, input int pipe_lat);
    return 1 + pipe_lat + size;
  endfunction

  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/mmu_skew.sv
// Per-lane delay line. Lane i is delayed DLY0 + i*DIR cycles; a delay of 0
// is a plain wire. Used both for input skew (DIR=+1) and output deskew
// (DIR=-1).
//   i_clk   : clock
//   i_reset : synchronous active-low reset, clears every stage
//   i_data  : LANES lanes of W bits, lane i at [i*W +: W]
//   o_data  : delayed lanes, same packing
module mmu_skew
  import mmu_pkg::*;
#(
  parameter int LANES = 4,
  parameter int W     = 8,
  parameter int DLY0  = 0,
  parameter int DIR   = 1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [LANES*W-1:0] i_data,
  output logic [LANES*W-1:0] o_data
);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam int D = DLY0 + i * DIR;
    if (D == 0) begin : g_pass
      assign o_data[lane_lo(i, W) +: W] = i_data[lane_lo(i, W) +: W];
    end else begin : g_dly
      logic [D-1:0][W-1:0] r_sh;
      always_ff @(posedge i_clk) begin
        if (!i_reset) begin
          r_sh <= '0;
        end else begin
          r_sh[0] <= i_data[lane_lo(i, W) +: W];
          for (int j = 1; j < D; j++) r_sh[j] <= r_sh[j-1];
        end
      end
      assign o_data[lane_lo(i, W) +: W] = r_sh[D-1];
    end
  end

endmodule

// File: rtl/mmu_sched.sv
// Job sequencer for the SIZE x SIZE systolic MMU.
// Per job: reset the array, shift one weight tile in (row SIZE-1 first),
// stream num_vec activation vectors with per-lane input skew, then deskew
// the accumulator lanes and emit one aligned result per vector.
//   i_clk, i_reset          : clock, synchronous active-low reset
//   i_start, i_num_vec      : job request (IDLE only) and vector count
//   o_busy, o_done          : job in progress / 1-cycle end pulse
//   o_wt_rd_*, i_wt_rd_data : weight buffer port (1-cycle read latency)
//   o_act_rd_*, i_act_rd_data : activation buffer port (1-cycle latency)
//   o_mmu_*, i_mmu_acc_out  : MMU instance control, data and results
//   o_res_valid/addr/data   : aligned result vector stream, no backpressure
module mmu_sched
  import mmu_pkg::*;
#(
  parameter  int SIZE      = 4,
  parameter  int BIT_WIDTH = 8,
  parameter  int ACC_WIDTH = 32,
  parameter  int MAX_VEC   = 256,
  parameter  int PIPE_LAT  = 5,
  localparam int ADDR_W    = $clog2(MAX_VEC),
  localparam int WA_W      = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_start,
  input  logic [ADDR_W:0]           i_num_vec,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_wt_rd_en,
  output logic [WA_W-1:0]           o_wt_rd_addr,
  input  logic [BIT_WIDTH*SIZE-1:0] i_wt_rd_data,
  output logic                      o_act_rd_en,
  output logic [ADDR_W-1:0]         o_act_rd_addr,
  input  logic [BIT_WIDTH*SIZE-1:0] i_act_rd_data,
  output logic                      o_mmu_rst,
  output logic                      o_mmu_control,
  output logic [BIT_WIDTH*SIZE-1:0] o_mmu_data_arr,
  output logic [BIT_WIDTH*SIZE-1:0] o_mmu_wt_arr,
  input  logic [ACC_WIDTH*SIZE-1:0] i_mmu_acc_out,
  output logic                      o_res_valid,
  output logic [ADDR_W-1:0]         o_res_addr,
  output logic [ACC_WIDTH*SIZE-1:0] o_res_data
);

  localparam int RES_LAT = res_lat(SIZE, PIPE_LAT);
  localparam int CNT_W   = $clog2(SIZE + 1);

  sched_state_e               r_state;
  logic                       r_busy, r_done;
  logic                       r_wt_rd_en, r_act_rd_en;
  logic [WA_W-1:0]            r_wt_rd_addr;
  logic [ADDR_W-1:0]          r_act_rd_addr;
  logic                       r_mmu_rst, r_mmu_control;
  logic [ADDR_W:0]            r_num_vec;
  logic [ADDR_W:0]            r_res_cnt;
  logic [CNT_W-1:0]           r_cnt;

  // Bit k tracks the vector whose act_rd_en was k+1 cycles ago.
  logic [RES_LAT-1:0]              r_vld_pipe;
  logic [RES_LAT-1:0][ADDR_W-1:0]  r_addr_pipe;
  logic [ACC_WIDTH*SIZE-1:0]       r_res_data;

  logic [BIT_WIDTH*SIZE-1:0]  w_act_in;
  logic [ACC_WIDTH*SIZE-1:0]  w_deskew;
  logic                       w_res_fire;

  assign w_res_fire = r_vld_pipe[RES_LAT-1];

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state       <= IDLE;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_wt_rd_en    <= 1'b0;
      r_wt_rd_addr  <= '0;
      r_act_rd_en   <= 1'b0;
      r_act_rd_addr <= '0;
      r_mmu_rst     <= 1'b1;
      r_mmu_control <= 1'b0;
      r_num_vec     <= '0;
      r_res_cnt     <= '0;
      r_cnt         <= '0;
    end else begin
      if (w_res_fire) r_res_cnt <= r_res_cnt + 1'b1;
      case (r_state)
        IDLE: begin
          r_mmu_rst <= 1'b0;
          if (i_start) begin
            r_state      <= LOAD_WT;
            r_busy       <= 1'b1;
            r_mmu_rst    <= 1'b1;
            r_num_vec    <= i_num_vec;
            r_res_cnt    <= '0;
            r_cnt        <= '0;
            r_wt_rd_en   <= 1'b1;
            r_wt_rd_addr <= WA_W'(SIZE - 1);
          end
        end
        LOAD_WT: begin
          // Reads issue on cnt 0..SIZE-1; each row reaches the array one
          // cycle later, so the shift strobe trails the read strobe by one.
          r_mmu_rst     <= 1'b0;
          r_cnt         <= r_cnt + 1'b1;
          r_wt_rd_en    <= (r_cnt < CNT_W'(SIZE - 1));
          r_mmu_control <= (r_cnt < CNT_W'(SIZE));
          if (r_wt_rd_addr != '0) r_wt_rd_addr <= r_wt_rd_addr - 1'b1;
          if (r_cnt == CNT_W'(SIZE)) begin
            if (r_num_vec == '0) begin
              r_state <= DRAIN;
            end else begin
              r_state       <= COMPUTE;
              r_act_rd_en   <= 1'b1;
              r_act_rd_addr <= '0;
            end
          end
        end
        COMPUTE: begin
          if ({1'b0, r_act_rd_addr} == r_num_vec - (ADDR_W+1)'(1)) begin
            r_state       <= DRAIN;
            r_act_rd_en   <= 1'b0;
            r_act_rd_addr <= '0;
          end else begin
            r_act_rd_addr <= r_act_rd_addr + 1'b1;
          end
        end
        DRAIN: begin
          // Count includes a result leaving the pipe this very cycle.
          if (r_res_cnt + (ADDR_W+1)'(w_res_fire) == r_num_vec) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_vld_pipe  <= '0;
      r_addr_pipe <= '0;
      r_res_data  <= '0;
    end else begin
      r_vld_pipe  <= {r_vld_pipe[RES_LAT-2:0], r_act_rd_en};
      r_addr_pipe <= {r_addr_pipe[RES_LAT-2:0], r_act_rd_addr};
      r_res_data  <= r_vld_pipe[RES_LAT-2] ? w_deskew : '0;
    end
  end

  // Only real activation data enters the skew line; idle lanes stay zero.
  assign w_act_in = r_vld_pipe[0] ? i_act_rd_data : '0;

  mmu_skew #(
    .LANES (SIZE),
    .W     (BIT_WIDTH),
    .DLY0  (0),
    .DIR   (1)
  ) u_in_skew (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_data  (w_act_in),
    .o_data  (o_mmu_data_arr)
  );

  mmu_skew #(
    .LANES (SIZE),
    .W     (ACC_WIDTH),
    .DLY0  (SIZE - 1),
    .DIR   (-1)
  ) u_out_deskew (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_data  (i_mmu_acc_out),
    .o_data  (w_deskew)
  );

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_wt_rd_en    = r_wt_rd_en;
  assign o_wt_rd_addr  = r_wt_rd_addr;
  assign o_act_rd_en   = r_act_rd_en;
  assign o_act_rd_addr = r_act_rd_addr;
  assign o_mmu_rst     = r_mmu_rst;
  assign o_mmu_control = r_mmu_control;
  assign o_mmu_wt_arr  = r_mmu_control ? i_wt_rd_data : '0;
  assign o_res_valid   = w_res_fire;
  assign o_res_addr    = r_addr_pipe[RES_LAT-1];
  assign o_res_data    = r_res_data;

endmodule
